axis_pkt_fifo: RTL and testbench

Parametrised AXI-stream-style FIFO with per-word `last` tracking, fill-level reporting and an optional store-and-forward packet mode. It sits between a stream producer (for example, a counter or source block) and a downstream consumer. It buffers words and packets behind the same write-gate and read-gate handshake (`writeReq` / `readReq`) used by the existing fixed-size FIFO. It generalises width, depth and thresholds, and adds packet accounting.

---
 rtl/axis_pkt_fifo.sv | 129 ++++++++++++
 tb/tb_axis_pkt_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// Stream FIFO with per-word last flag, fill-level flags and packet counting.
// Define AXIS_PKT_FIFO_PACKET_MODE_EN for store-and-forward release of whole packets.
module axis_pkt_fifo #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DEPTH              = 4096,
    parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 8,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeReq,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic                    writeDataValid,
    output logic                    writeDataReady,
    input  logic                    writeDataLast,
    input  logic                    readReq,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readDataValid,
    input  logic                    readDataReady,
    output logic                    readDataLast,
    output logic                    full,
    output logic                    empty,
    output logic                    almostFull,
    output logic                    almostEmpty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  pktCount
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_pkt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_release;
    logic                  w_wbeat;
    logic                  w_rbeat;
    logic                  w_load;
    logic [CW-1:0]         w_mem_cnt;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         w_pkt_nxt;

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    logic r_escape;

    // Hold a word back until its packet is complete, unless a full FIFO holds no
    // complete packet, in which case drain freely until a last word leaves.
    assign w_release = (r_pkt != '0) | r_escape | (r_full & (r_pkt == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_escape <= 1'b0;
        end else begin
            r_escape <= (r_escape | (r_full & (r_pkt == '0))) & ~(w_rbeat & r_out_last);
        end
    end
`else
    assign w_release = 1'b1;
`endif

    assign writeDataReady = writeReq & ~r_full & reset;
    assign readDataValid  = r_out_valid & readReq & w_release;
    assign readData       = r_out_data;
    assign readDataLast   = r_out_last;
    assign full           = r_full;
    assign empty          = r_empty;
    assign almostFull     = r_af;
    assign almostEmpty    = r_ae;
    assign count          = r_count;
    assign pktCount       = r_pkt;

    assign w_wbeat     = writeDataValid & writeDataReady;
    assign w_rbeat     = readDataValid & readDataReady;
    // Words in the array only; the output register is counted separately.
    assign w_mem_cnt   = r_count - CW'(r_out_valid);
    assign w_load      = (w_mem_cnt != '0) & (~r_out_valid | w_rbeat);
    assign w_count_nxt = r_count + CW'(w_wbeat) - CW'(w_rbeat);
    assign w_pkt_nxt   = r_pkt + CW'(w_wbeat & writeDataLast) - CW'(w_rbeat & r_out_last);

    always_ff @(posedge clk) begin
        if (w_wbeat) begin
            r_mem[r_wr_ptr] <= {writeDataLast, writeData};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_count     <= '0;
            r_pkt       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_af        <= 1'b0;
            r_ae        <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_pkt   <= w_pkt_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= CW'(ALMOST_FULL_LEVEL));
            r_ae    <= (w_count_nxt <= CW'(ALMOST_EMPTY_LEVEL));
            if (w_wbeat) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr                 <= r_rd_ptr + AW'(1);
                r_out_valid              <= 1'b1;
                {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
            end else if (w_rbeat) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: queue-based reference model, directed
// scenarios and randomized traffic. Honours AXIS_PKT_FIFO_PACKET_MODE_EN.
module tb_axis_pkt_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;
    localparam int unsigned AEL   = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          writeReq = 1'b0;
    logic [DW-1:0] writeData = '0;
    logic          writeDataValid = 1'b0;
    logic          writeDataReady;
    logic          writeDataLast = 1'b0;
    logic          readReq = 1'b0;
    logic [DW-1:0] readData;
    logic          readDataValid;
    logic          readDataReady = 1'b0;
    logic          readDataLast;
    logic          full, empty, almostFull, almostEmpty;
    logic [CW-1:0] count, pktCount;

    axis_pkt_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .clk(clk), .reset(reset),
        .writeReq(writeReq), .writeData(writeData), .writeDataValid(writeDataValid),
        .writeDataReady(writeDataReady), .writeDataLast(writeDataLast),
        .readReq(readReq), .readData(readData), .readDataValid(readDataValid),
        .readDataReady(readDataReady), .readDataLast(readDataLast),
        .full(full), .empty(empty), .almostFull(almostFull), .almostEmpty(almostEmpty),
        .count(count), .pktCount(pktCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: everything held, head first, as {last, data}; plus head visibility.
    logic [DW:0]   mq[$];
    bit            m_ov  = 1'b0;
    bit            m_esc = 1'b0;

    // Words seen leaving the DUT.
    logic [DW-1:0] rx_d[$];
    bit            rx_l[$];
    int            rx_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_pkt();
        int n = 0;
        foreach (mq[i]) if (mq[i][DW]) n++;
        return n;
    endfunction

    function automatic bit m_rel();
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        return (m_pkt() > 0) || m_esc || (mq.size() == DEPTH && m_pkt() == 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check();
        int sz = mq.size();
        bit rv = m_ov && readReq && m_rel();
        chk("wready", writeDataReady, writeReq && reset && sz != DEPTH);
        chk("rvalid", readDataValid, rv);
        chk("count", count, sz);
        chk("pktcount", pktCount, m_pkt());
        chk("full", full, sz == DEPTH);
        chk("empty", empty, sz == 0);
        chk("almostfull", almostFull, sz >= AFL);
        chk("almostempty", almostEmpty, sz <= AEL);
        if (m_ov) begin
            chk("rdata", readData, mq[0][DW-1:0]);
            chk("rlast", readDataLast, mq[0][DW]);
        end
    endtask

    task automatic step(input bit wr, input bit wv, input logic [DW-1:0] wd, input bit wl,
                        input bit rq, input bit rr, input bit rst);
        int  sz, pk, msz;
        bit  full_pre, wbeat, rbeat;
        writeReq = wr; writeDataValid = wv; writeData = wd; writeDataLast = wl;
        readReq = rq; readDataReady = rr; reset = rst;
        #1;
        if (readDataValid && readDataReady && reset) begin
            rx_d.push_back(readData);
            rx_l.push_back(readDataLast);
            rx_c.push_back(cyc);
        end
        sz       = mq.size();
        pk       = m_pkt();
        full_pre = (sz == DEPTH);
        wbeat    = wv && wr && rst && !full_pre;
        rbeat    = rst && m_ov && rq && rr && m_rel();
        msz      = sz - int'(m_ov);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_ov  = 1'b0;
            m_esc = 1'b0;
        end else begin
            m_esc = (m_esc || (full_pre && pk == 0)) && !(rbeat && mq[0][DW]);
            if (rbeat) void'(mq.pop_front());
            if (wbeat) mq.push_back({wl, wd});
            if (!m_ov || rbeat) m_ov = (msz > 0);
        end
        cyc++;
        @(negedge clk);
        check();
    endtask

    task automatic rx_clear();
        rx_d.delete(); rx_l.delete(); rx_c.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && count != 0; i++) step(1, 0, '0, 0, 1, 1, 1);
        chk("drained", count, 0);
    endtask

    initial begin
        // Reset held with a producer pushing.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, DW'(5), 0, 1, 1, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_count", count, 0);
            chk("rst_wready", writeDataReady, 0);
            chk("rst_rvalid", readDataValid, 0);
            chk("rst_rdata", readData, 0);
            chk("rst_aempty", almostEmpty, 1);
        end

        // Streaming 1..20, packet closed on 20.
        rx_clear();
        for (int i = 1; i <= 20; i++) step(1, 1, DW'(i), i == 20, 1, 1, 1);
        drain(40);
        chk("ct_len", rx_d.size(), 20);
        for (int i = 0; i < rx_d.size() && i < 20; i++) begin
            chk("ct_data", rx_d[i], i + 1);
            chk("ct_last", rx_l[i], i == 19);
            chk("ct_gap", rx_c[i] - rx_c[0], i);
        end

        // Fill to full with the read gate closed.
        for (int j = 1; j <= DEPTH; j++) begin
            step(1, 1, DW'(100 + j), 0, 0, 1, 1);
            if (j == AFL - 1) chk("af_below", almostFull, 0);
            if (j == AFL)     chk("af_at", almostFull, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, DEPTH);
        writeReq = 1; writeDataValid = 1; readReq = 0; #1;
        chk("fill_refused", writeDataReady, 0);
        step(1, 1, DW'(999), 0, 0, 1, 1);
        chk("fill_still", count, DEPTH);
        rx_clear();
        step(1, 0, '0, 0, 1, 1, 1);
        chk("fill_rd_n", rx_d.size(), 1);
        if (rx_d.size() > 0) chk("fill_rd_d", rx_d[0], 101);
        chk("fill_wrise", writeDataReady, 1);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 1, 1, 1);
        chk("at_ten", count, 10);

        // Concurrent read and write at a constant level.
        rx_clear();
        for (int i = 0; i < 50; i++) begin
            step(1, 1, DW'(200 + i), 0, 1, 1, 1);
            chk("rw_count", count, 10);
        end
        chk("rw_len", rx_d.size(), 50);
        for (int i = 0; i < rx_d.size() && i < 50; i++)
            chk("rw_order", rx_d[i], (i < 10) ? (107 + i) : (200 + i - 10));

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        // Store-and-forward: nothing leaves until the last word arrives.
        step(1, 0, '0, 0, 0, 0, 0);
        rx_clear();
        for (int i = 1; i <= 19; i++) begin
            step(1, 1, DW'(i), 0, 1, 1, 1);
            chk("pm_hold", readDataValid, 0);
        end
        step(1, 1, DW'(20), 1, 1, 1, 1);
        chk("pm_pkt", pktCount, 1);
        step(1, 0, '0, 0, 1, 1, 1);
        chk("pm_rv", readDataValid, 1);
        drain(40);
        chk("pm_len", rx_d.size(), 20);
        for (int i = 0; i < rx_d.size() && i < 20; i++) begin
            chk("pm_data", rx_d[i], i + 1);
            chk("pm_last", rx_l[i], i == 19);
        end

        // A full FIFO with no complete packet must still drain.
        step(1, 0, '0, 0, 0, 0, 0);
        rx_clear();
        for (int j = 1; j <= DEPTH; j++) begin
            step(1, 1, DW'(j), 0, 1, 1, 1);
            if (j < DEPTH) chk("dl_hold", readDataValid, 0);
        end
        chk("dl_full", full, 1);
        chk("dl_rv", readDataValid, 1);
        drain(40);
        chk("dl_len", rx_d.size(), DEPTH);
`endif

        // Randomized traffic with phases biased toward full and toward empty.
        step(1, 0, '0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            int ph = (c / 250) % 3;
            int wp = (ph == 1) ? 90 : (ph == 2) ? 25 : 60;
            int rp = (ph == 1) ? 25 : (ph == 2) ? 90 : 60;
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < wp),
                 DW'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 299) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
